// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: VGA raster timing (pixel enable, h/v counters, syncs, video_on).
// Optional 8-bit frame counter is built only when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_ctrl #(
    parameter int DIV       = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixelx,
    output logic [9:0] pixely,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
    localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          line_end;

    // >= compares pull any out-of-range count back to 0 on the next tick
    always_comb begin
        p_tick      = div_cnt == DIV_MAX;
        line_end    = pixelx >= H_MAX;
        h_next      = p_tick ? (line_end ? '0 : pixelx + 10'd1) : pixelx;
        v_next      = (p_tick && line_end) ? (pixely >= V_MAX ? '0 : pixely + 10'd1) : pixely;
        video_on    = (pixelx < H_VIS) && (pixely < V_VIS);
        frame_start = p_tick && (pixelx == H_MAX) && (pixely == V_MAX);
    end

    // syncs decode the next counts so they switch on the same edge as pixelx/pixely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            pixelx  <= '0;
            pixely  <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            div_cnt <= (div_cnt >= DIV_MAX) ? '0 : div_cnt + DW'(1);
            pixelx  <= h_next;
            pixely  <= v_next;
            hsync   <= !(h_next >= HS_LO && h_next <= HS_HI);
            vsync   <= !(v_next >= VS_LO && v_next <= VS_HI);
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt <= '0;
        else if (frame_start)
            frame_cnt <= frame_cnt + 8'd1;
    end
`else
    assign frame_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl: default-size and shrunk-raster instances checked every cycle
// against a closed-form position model driven by the count of clocks since reset.
module tb_vga_sync_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   c = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   checking = 1'b0;

    logic       d_pt, d_von, d_hs, d_vs, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic       s_pt, s_von, s_hs, s_vs, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    always #5 clk = ~clk;

    vga_sync_ctrl dut_d (
        .clk(clk), .reset(reset), .p_tick(d_pt), .pixelx(d_x), .pixely(d_y),
        .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_sync_ctrl #(
        .DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut_s (
        .clk(clk), .reset(reset), .p_tick(s_pt), .pixelx(s_x), .pixely(s_y),
        .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       von, hs, vs, fs;
        logic [7:0] fc;
    } exp_t;

    // c = clocks since reset release; t = completed pixel ticks
    function automatic exp_t model(int cc, int dv, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb);
        exp_t m;
        int ht = hd + hf + hsw + hb;
        int vt = vd + vf + vsw + vb;
        int t  = cc / dv;
        int h  = t % ht;
        int v  = (t / ht) % vt;
        m.pt  = (cc % dv) == dv - 1;
        m.x   = 10'(h);
        m.y   = 10'(v);
        m.von = (h < hd) && (v < vd);
        m.hs  = !(h >= hd + hf && h < hd + hf + hsw);
        m.vs  = !(v >= vd + vf && v < vd + vf + vsw);
        m.fs  = m.pt && h == ht - 1 && v == vt - 1;
`ifdef VGA_SYNC_FRAME_CNT_EN
        m.fc  = 8'((t / (ht * vt)) % 256);
`else
        m.fc  = 8'h00;
`endif
        return m;
    endfunction

    function automatic exp_t exp_d(int cc);
        return model(cc, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic exp_t exp_s(int cc);
        return model(cc, 3, 8, 2, 3, 2, 6, 2, 2, 2);
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at c=%0d t=%0t: got %0d, expected %0d", name, c, $time, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e, input logic pt, input logic [9:0] x,
                           input logic [9:0] y, input logic von, input logic hs, input logic vs,
                           input logic fs, input logic [7:0] fc);
        chk({tag, ".p_tick"}, 10'(pt), 10'(e.pt));
        chk({tag, ".pixelx"}, x, e.x);
        chk({tag, ".pixely"}, y, e.y);
        chk({tag, ".video_on"}, 10'(von), 10'(e.von));
        chk({tag, ".hsync"}, 10'(hs), 10'(e.hs));
        chk({tag, ".vsync"}, 10'(vs), 10'(e.vs));
        chk({tag, ".frame_start"}, 10'(fs), 10'(e.fs));
        chk({tag, ".frame_cnt"}, 10'(fc), 10'(e.fc));
    endtask

    always @(posedge clk or posedge reset)
        if (reset) c <= 0;
        else c <= c + 1;

    always @(negedge clk)
        if (checking) begin
            chk_all("d", exp_d(c), d_pt, d_x, d_y, d_von, d_hs, d_vs, d_fs, d_fc);
            chk_all("s", exp_s(c), s_pt, s_x, s_y, s_von, s_hs, s_vs, s_fs, s_fc);
        end

    task automatic run_to(input int target);
        repeat (target - c) @(negedge clk);
    endtask

    initial begin
        checking = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset.video_on", 10'(d_von), 10'd1);
        chk("reset.hsync", 10'(d_hs), 10'd1);
        reset = 1'b0;
        run_to(3);
        chk("first_tick", 10'(d_pt), 10'd1);
        run_to(539);
        chk("s.frame_start_pre", 10'(s_fs), 10'd1);
        chk("s.x_pre", s_x, 10'd14);
        chk("s.y_pre", s_y, 10'd11);
        run_to(540);
        chk("s.x_wrap", s_x, 10'd0);
        chk("s.y_wrap", s_y, 10'd0);
        chk("s.vsync_wrap", 10'(s_vs), 10'd1);
        chk("s.frame_start_post", 10'(s_fs), 10'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("s.frame_cnt_wrap", 10'(s_fc), 10'd1);
`else
        chk("s.frame_cnt_wrap", 10'(s_fc), 10'd0);
`endif
        run_to(2560);
        chk("d.video_off_640", 10'(d_von), 10'd0);
        chk("d.x640", d_x, 10'd640);
        run_to(2623);
        chk("d.x655", d_x, 10'd655);
        chk("d.hsync_655", 10'(d_hs), 10'd1);
        run_to(2624);
        chk("d.x656", d_x, 10'd656);
        chk("d.hsync_656", 10'(d_hs), 10'd0);
        run_to(3007);
        chk("d.hsync_751", 10'(d_hs), 10'd0);
        run_to(3008);
        chk("d.x752", d_x, 10'd752);
        chk("d.hsync_752", 10'(d_hs), 10'd1);
        run_to(3200);
        chk("d.line_wrap_x", d_x, 10'd0);
        chk("d.line_wrap_y", d_y, 10'd1);
        run_to(4400);
        @(posedge clk);
        #2;
        chk("d.x300_pre_reset", d_x, 10'd300);
        reset = 1'b1;
        #1;
        chk("d.async_reset_x", d_x, 10'd0);
        chk("d.async_reset_hsync", 10'(d_hs), 10'd1);
        chk("s.async_reset_x", s_x, 10'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(1, 1500)) @(negedge clk);
            @(posedge clk);
            #($urandom_range(1, 8));
            reset = 1'b1;
            #1;
            chk("async_reset_x", d_x, 10'd0);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (2000) @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
